dds_word_gen: RTL

Converts the SPI-written configuration words into the live frequency, phase and amplitude words that drive the DDS core. It sits directly downstream of the SPI configuration register file and consumes its `mode`, `direct_*` and `drg_*` outputs plus the `param_wen` strobe. It either passes the direct words through or runs a digital ramp (sweep) on all three channels at a fixed dwell rate. Outputs are registered and go straight to the phase accumulator and amplitude multiplier.

---
 rtl/dds_word_gen_if.sv | 43 ++++
 rtl/dds_word_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_word_gen_if.sv
// dds_word_gen_if: configuration and output bundle for dds_word_gen.
// master = configuration source (SPI register file side), slave = word generator.
interface dds_word_gen_if;
    logic        param_wen;
    logic [31:0] mode;
    logic [31:0] direct_fword;
    logic [31:0] direct_pword;
    logic [31:0] direct_amp;
    logic [31:0] drg_f_start;
    logic [31:0] drg_f_end;
    logic [31:0] drg_f_step;
    logic [31:0] drg_p_start;
    logic [31:0] drg_p_end;
    logic [31:0] drg_p_step;
    logic [31:0] drg_a_start;
    logic [31:0] drg_a_end;
    logic [31:0] drg_a_step;
    logic        trig;
    logic [31:0] fword;
    logic [31:0] pword;
    logic [31:0] amp;
    logic        out_valid;
    logic        busy;
    logic        done;

    modport master (
        output param_wen, mode, direct_fword, direct_pword, direct_amp,
        output drg_f_start, drg_f_end, drg_f_step,
        output drg_p_start, drg_p_end, drg_p_step,
        output drg_a_start, drg_a_end, drg_a_step,
        output trig,
        input  fword, pword, amp, out_valid, busy, done
    );

    modport slave (
        input  param_wen, mode, direct_fword, direct_pword, direct_amp,
        input  drg_f_start, drg_f_end, drg_f_step,
        input  drg_p_start, drg_p_end, drg_p_step,
        input  drg_a_start, drg_a_end, drg_a_step,
        input  trig,
        output fword, pword, amp, out_valid, busy, done
    );
endinterface

// File: rtl/dds_word_gen.sv
// dds_word_gen: turns shadowed configuration words into live DDS frequency,
// phase and amplitude words, either passed straight through or ramped.
// Optional feature macro: DDS_WORD_GEN_TRIANGLE_EN -- when defined, mode 3
// reverses ramp direction at each end; otherwise mode 3 acts like mode 2.
// Channel index: 0 = frequency, 1 = phase, 2 = amplitude.
module dds_word_gen #(
    parameter int DWELL = 50
) (
    input  logic          clk,
    input  logic          rstn,
    dds_word_gen_if.slave bus
);
    localparam int CW = $clog2(DWELL + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [1:0] M_DIRECT = 2'd0;
    localparam logic [1:0] M_SINGLE = 2'd1;
    localparam logic [1:0] M_TRI    = 2'd3;

    logic [2:0]        state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [1:0]        mode_reg;
    logic [2:0][31:0]  direct_reg, start_reg, end_reg, step_reg;
    logic [2:0][31:0]  out_reg, out_next;
    logic              out_valid_reg, out_valid_next;
    logic              done_reg, done_next;

    logic [2:0][31:0]  cur_target, eff_target, step_val;
    logic [2:0]        asc, eff_up, at_target, lands_end;
    logic              all_at_target, all_land, tick, run_tick, tri_flip;
    logic              unused_mode_bits;

    assign unused_mode_bits = ^bus.mode[31:2];

    // One clamped step from cur toward target; 33-bit so nothing wraps.
    function automatic logic [31:0] ramp_step(input logic [31:0] cur,
                                              input logic [31:0] step,
                                              input logic [31:0] target,
                                              input logic        up);
        logic [32:0] sum;
        logic [32:0] diff;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        if (up)
            ramp_step = (sum >= {1'b0, target}) ? target : sum[31:0];
        else
            ramp_step = (diff[32] || (diff[31:0] <= target)) ? target : diff[31:0];
    endfunction

`ifdef DDS_WORD_GEN_TRIANGLE_EN
    logic       back_reg;   // 1 while heading back toward the start values
    logic [2:0] dir_reg;    // per-channel current direction, 1 = ascending

    assign tri_flip = (mode_reg == M_TRI) && all_at_target;

    // Direction flags: seeded on LOAD, all flipped at each turning point.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            back_reg <= 1'b0;
            dir_reg  <= 3'b000;
        end else if (state_reg == S_LOAD && !bus.param_wen) begin
            back_reg <= 1'b0;
            dir_reg  <= asc;
        end else if (run_tick && tri_flip) begin
            back_reg <= ~back_reg;
            dir_reg  <= ~dir_reg;
        end
    end
`else
    assign tri_flip = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            assign asc[gi] = (end_reg[gi] >= start_reg[gi]);
`ifdef DDS_WORD_GEN_TRIANGLE_EN
            assign cur_target[gi] = back_reg ? start_reg[gi] : end_reg[gi];
            assign eff_target[gi] = (back_reg ^ tri_flip) ? start_reg[gi] : end_reg[gi];
            assign eff_up[gi]     = dir_reg[gi] ^ tri_flip;
`else
            assign cur_target[gi] = end_reg[gi];
            assign eff_target[gi] = end_reg[gi];
            assign eff_up[gi]     = asc[gi];
`endif
            // A zero step never moves, so it counts as already arrived.
            assign at_target[gi] = (out_reg[gi] == cur_target[gi]) || (step_reg[gi] == 32'd0);
            assign step_val[gi]  = ramp_step(out_reg[gi], step_reg[gi], eff_target[gi], eff_up[gi]);
            assign lands_end[gi] = (step_val[gi] == end_reg[gi]) || (step_reg[gi] == 32'd0);
        end
    endgenerate

    assign all_at_target = &at_target;
    assign all_land      = &lands_end;
    assign tick          = (cnt_reg == CW'(DWELL - 1));
    assign run_tick      = (state_reg == S_RUN) && !done_reg && tick && !bus.param_wen;

    // Shadow registers: configuration is only sampled on param_wen.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mode_reg   <= '0;
            direct_reg <= '0;
            start_reg  <= '0;
            end_reg    <= '0;
            step_reg   <= '0;
        end else if (bus.param_wen) begin
            mode_reg   <= bus.mode[1:0];
            direct_reg <= {bus.direct_amp, bus.direct_pword, bus.direct_fword};
            start_reg  <= {bus.drg_a_start, bus.drg_p_start, bus.drg_f_start};
            end_reg    <= {bus.drg_a_end, bus.drg_p_end, bus.drg_f_end};
            step_reg   <= {bus.drg_a_step, bus.drg_p_step, bus.drg_f_step};
        end
    end

    // Next-state, dwell counter and output word selection.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        out_next       = out_reg;
        out_valid_next = 1'b0;
        done_next      = 1'b0;
        if (bus.param_wen) begin
            state_next = S_LOAD;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_next = S_IDLE;
                end
                S_LOAD: begin
                    cnt_next       = '0;
                    out_valid_next = 1'b1;
                    if (mode_reg == M_DIRECT) begin
                        out_next   = direct_reg;
                        state_next = S_HOLD;
                    end else begin
                        out_next   = start_reg;
                        state_next = (mode_reg == M_SINGLE) ? S_ARMED : S_RUN;
                    end
                end
                S_ARMED: begin
                    if (bus.trig) begin
                        state_next = S_RUN;
                        cnt_next   = '0;
                    end
                end
                S_HOLD: begin
                    if (bus.trig && mode_reg == M_SINGLE) begin
                        out_next       = start_reg;
                        out_valid_next = 1'b1;
                        state_next     = S_RUN;
                        cnt_next       = '0;
                    end
                end
                S_RUN: begin
                    if (done_reg) begin
                        // Final sweep word already out; busy drops now.
                        state_next = S_HOLD;
                    end else if (tick) begin
                        cnt_next       = '0;
                        out_valid_next = 1'b1;
                        if (mode_reg == M_SINGLE) begin
                            out_next  = step_val;
                            done_next = all_land;
                        end else if (all_at_target && !tri_flip) begin
                            out_next = start_reg;
                        end else begin
                            out_next = step_val;
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            done_reg      <= done_next;
        end
    end

    assign bus.fword     = out_reg[0];
    assign bus.pword     = out_reg[1];
    assign bus.amp       = out_reg[2];
    assign bus.out_valid = out_valid_reg;
    assign bus.done      = done_reg;
    assign bus.busy      = (state_reg == S_RUN);
endmodule
